final_tcp_hw_nios2_cpu_debug_slave_ocimem: RTL

Debug monitor memory for the Nios II debug slave, clocked on `clk`. It sits directly downstream of the debug slave's system-clock stage and consumes its `jdo` bus and `take_action_ocimem_*` pulses. It owns a 256×32 on-chip debug RAM and arbitrates it between JTAG host accesses and CPU debug-slave accesses. It returns captured read data to the JTAG path as `MonDReg`.

---
 rtl/final_tcp_hw_nios2_cpu_debug_pkg.sv | 19 +
 rtl/final_tcp_hw_nios2_cpu_debug_slave_ociram.sv | 35 +++
 rtl/final_tcp_hw_nios2_cpu_debug_slave_ocimem.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/final_tcp_hw_nios2_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug-slave OCI memory: FSM encoding and
// field positions inside the jdo bus handed over by the sysclk stage.
package final_tcp_hw_nios2_cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_JWR  = 2'd2,
        ST_CPU  = 2'd3
    } ocimem_state_e;

    localparam int JDO_RD_BIT      = 35;
    localparam int JDO_ADDR_HI     = 33;
    localparam int JDO_ADDR_LO     = 26;
    localparam int JDO_DATA_HI     = 34;
    localparam int JDO_DATA_LO     = 3;
    localparam int OCI_RAM_SEL_BIT = 8;

endpackage

// File: rtl/final_tcp_hw_nios2_cpu_debug_slave_ociram.sv
// Single-port debug RAM with byte lanes; read data is registered, so a read
// issued on one edge is visible for the whole following cycle.
module final_tcp_hw_nios2_cpu_debug_slave_ociram #(
    parameter int RAM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       q
);

    logic [31:0] mem_q [RAM_WORDS];
    logic [31:0] rdata_q;

    // Read-during-write returns the word as it was before the write.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign q = rdata_q;

endmodule

// File: rtl/final_tcp_hw_nios2_cpu_debug_slave_ocimem.sv
// Debug monitor memory: arbitrates the OCI RAM between JTAG monitor accesses
// (MonAReg/MonDReg) and CPU debug-slave accesses, JTAG first.
//
//   state | meaning
//   IDLE  | arbitrate; issue pending JTAG read, then JTAG write, then CPU
//   JRD   | RAM word for the JTAG read is on q; capture into MonDReg
//   JWR   | JTAG write done; step MonAReg
//   CPU   | CPU access acknowledged; RAM q drives readdata
module final_tcp_hw_nios2_cpu_debug_slave_ocimem
    import final_tcp_hw_nios2_cpu_debug_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [37:0]     jdo,
    input  logic            take_action_ocimem_a,
    input  logic            take_no_action_ocimem_a,
    input  logic            take_action_ocimem_b,
    input  logic [ADDR_W:0] address,
    input  logic            chipselect,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     writedata,
    input  logic [3:0]      byteenable,
    input  logic            debugaccess,
    output logic [31:0]     MonDReg,
    output logic [31:0]     readdata,
    output logic            waitrequest,
    output logic            jtag_busy
);

    ocimem_state_e     state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              jtag_rd_q, jtag_rd_d;
    logic              jtag_wr_q, jtag_wr_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_q;
    logic [3:0]        ram_be;
    logic              cpu_req, cpu_ext;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[37:36], jdo[JDO_DATA_LO-1:0]};

    assign cpu_ext = chipselect & (read | write) & address[OCI_RAM_SEL_BIT];
    assign cpu_req = chipselect & (read | write) & ~address[OCI_RAM_SEL_BIT];

    always_comb begin
        state_d    = state_q;
        mon_a_d    = mon_a_q;
        mon_d_d    = mon_d_q;
        jtag_rd_d  = jtag_rd_q;
        jtag_wr_d  = jtag_wr_q;
        readdata_d = readdata_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = mon_a_q;
        ram_wdata  = mon_d_q;
        ram_be     = 4'hF;

        // Flags drop at issue so a pulse landing during JRD/JWR is not lost.
        unique case (state_q)
            ST_IDLE: begin
                if (jtag_rd_q) begin
                    ram_en    = 1'b1;
                    jtag_rd_d = 1'b0;
                    state_d   = ST_JRD;
                end else if (jtag_wr_q) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    jtag_wr_d = 1'b0;
                    state_d   = ST_JWR;
                end else if (cpu_req) begin
                    ram_en    = 1'b1;
                    ram_we    = write & debugaccess;
                    ram_addr  = address[ADDR_W-1:0];
                    ram_wdata = writedata;
                    ram_be    = byteenable;
                    state_d   = ST_CPU;
                end
            end
            ST_JRD: begin
                mon_d_d = ram_q;
                state_d = ST_IDLE;
            end
            ST_JWR: begin
                mon_a_d = mon_a_q + 1'b1;
                state_d = ST_IDLE;
            end
            ST_CPU: begin
                readdata_d = ram_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Host pulses take precedence over the FSM's own register updates.
        if (take_action_ocimem_a) begin
            mon_a_d   = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
            jtag_rd_d = jdo[JDO_RD_BIT];
        end else if (take_no_action_ocimem_a) begin
            mon_a_d   = mon_a_q + 1'b1;
            jtag_rd_d = 1'b1;
        end else if (take_action_ocimem_b) begin
            mon_d_d   = jdo[JDO_DATA_HI:JDO_DATA_LO];
            jtag_wr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mon_a_q    <= '0;
            mon_d_q    <= '0;
            jtag_rd_q  <= 1'b0;
            jtag_wr_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            jtag_rd_q  <= jtag_rd_d;
            jtag_wr_q  <= jtag_wr_d;
            readdata_q <= readdata_d;
        end
    end

    final_tcp_hw_nios2_cpu_debug_slave_ociram #(
        .RAM_WORDS (RAM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_ociram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .q     (ram_q)
    );

    always_comb begin
        if (state_q == ST_CPU) begin
            readdata = ram_q;
        end else if (cpu_ext) begin
            readdata = '0;
        end else begin
            readdata = readdata_q;
        end
    end

    assign waitrequest = cpu_req & (state_q != ST_CPU);
    assign jtag_busy   = jtag_rd_q | jtag_wr_q | (state_q == ST_JRD) | (state_q == ST_JWR);
    assign MonDReg     = mon_d_q;

endmodule
